// File: rtl/counter_15_hwcheck_if.sv
// Stimulus/response bus between the counter checker and its driver.
// slave = checker side, master = environment/bench side.
interface counter_15_hwcheck_if;
  logic        start;
  logic [15:0] num_vec;
  logic [4:0]  C0;
  logic        C1;
  logic [2:0]  O;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [15:0] first_err_idx;
  logic [2:0]  first_err_exp;
  logic [2:0]  first_err_got;

  modport slave (
    input  start, num_vec, O,
    output C0, C1, busy, done, pass, err_cnt, first_err_idx, first_err_exp, first_err_got
  );

  modport master (
    output start, num_vec, O,
    input  C0, C1, busy, done, pass, err_cnt, first_err_idx, first_err_exp, first_err_got
  );
endinterface

// File: rtl/counter_15_hwcheck.sv
// Built-in self-check for a 5+1 input weighted counter: drives C0/C1, compares O LATENCY cycles later.
// Macro COUNTER_15_HWCHECK_EXHAUSTIVE_EN swaps the LFSR stimulus for a 6-bit binary sweep.
module counter_15_hwcheck #(
  parameter int          LATENCY = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  counter_15_hwcheck_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef COUNTER_15_HWCHECK_EXHAUSTIVE_EN
  localparam logic [15:0] GEN_INIT = 16'h0000;

  function automatic logic [15:0] gen_next(input logic [15:0] g);
    return g + 16'd1;
  endfunction
`else
  localparam logic [15:0] GEN_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // x^16+x^14+x^13+x^11+1, Fibonacci, shifting left
  function automatic logic [15:0] gen_next(input logic [15:0] g);
    return {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]};
  endfunction
`endif

  logic [1:0]  state;
  logic [15:0] gen;
  logic [15:0] gen_nx;
  logic [5:0]  stim;
  logic [15:0] rem;
  logic [3:0]  drain;
  logic        start_ok;

  logic              vld_in;
  logic [2:0]        exp_in;
  logic [LATENCY:1]  vld_pipe;
  logic [LATENCY:1][2:0] exp_pipe;

  logic [15:0] err_cnt;
  logic [15:0] cmp_idx;
  logic [15:0] first_idx;
  logic [2:0]  first_exp;
  logic [2:0]  first_got;

  assign gen_nx   = gen_next(gen);
  assign start_ok = bus.start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gen   <= GEN_INIT;
      stim  <= '0;
      rem   <= '0;
      drain <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            gen   <= GEN_INIT;
            rem   <= bus.num_vec;
            stim  <= (bus.num_vec != '0) ? GEN_INIT[5:0] : 6'd0;
            state <= (bus.num_vec != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          // stim already holds vector k; advance only if another vector follows
          if (rem == 16'd1) begin
            stim  <= '0;
            drain <= 4'(LATENCY - 1);
            state <= S_DRAIN;
          end else begin
            gen  <= gen_nx;
            stim <= gen_nx[5:0];
            rem  <= rem - 16'd1;
          end
        end
        S_DRAIN: begin
          if (drain == '0) state <= S_DONE;
          else             drain <= drain - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign vld_in = (state == S_RUN);

  always_comb begin
    exp_in = {1'b0, stim[5], 1'b0};
    for (int i = 0; i < 5; i++) exp_in = exp_in + {2'b00, stim[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
    end else begin
      vld_pipe[1] <= vld_in;
      exp_pipe[1] <= exp_in;
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  // cmp_idx tracks the vector index at the pipe tail, so no index needs pipelining
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_cnt   <= '0;
      cmp_idx   <= '0;
      first_idx <= '0;
      first_exp <= '0;
      first_got <= '0;
    end else if (vld_pipe[LATENCY]) begin
      cmp_idx <= cmp_idx + 16'd1;
      if (bus.O != exp_pipe[LATENCY]) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        if (err_cnt == '0) begin
          first_idx <= cmp_idx;
          first_exp <= exp_pipe[LATENCY];
          first_got <= bus.O;
        end
      end
    end
  end

  assign bus.C0            = stim[4:0];
  assign bus.C1            = stim[5];
  assign bus.busy          = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done          = (state == S_DONE);
  assign bus.pass          = (state == S_DONE) && (err_cnt == '0);
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_idx = first_idx;
  assign bus.first_err_exp = first_exp;
  assign bus.first_err_got = first_got;

endmodule

// File: tb/tb_counter_15_hwcheck.sv
// Bench for counter_15_hwcheck: table runs, hand sequences, random runs vs. a vector-list model.
module tb_counter_15_hwcheck;
  localparam int          LAT  = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_15_hwcheck_if bus();
  counter_15_hwcheck #(.LATENCY(LAT), .SEED(SEED)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;
  logic [5:0] hist [0:LAT] = '{default: 6'd0};

  // vector k of a run, straight from the stimulus rule
  function automatic logic [5:0] vec_k(input int k);
`ifdef COUNTER_15_HWCHECK_EXHAUSTIVE_EN
    return 6'(k % 64);
`else
    logic [15:0] s;
    s = (SEED == 16'h0) ? 16'h1 : SEED;
    for (int i = 0; i < k; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s[5:0];
`endif
  endfunction

  function automatic logic [2:0] exp_of(input logic [5:0] v);
    return 3'($countones(v[4:0]) + 2 * int'(v[5]));
  endfunction

  // counter-under-test behaviours: 0 ideal, 1 stuck-at-0, 2 wrong only on sum 4, 3 lsb flipped
  function automatic logic [2:0] cut(input int m, input logic [2:0] e);
    case (m)
      1:       return 3'd0;
      2:       return (e == 3'd4) ? 3'd5 : e;
      3:       return e ^ 3'd1;
      default: return e;
    endcase
  endfunction

  // emulated counter under test: O in cycle t answers C from cycle t-LAT
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {bus.C1, bus.C0};
    bus.O = cut(mode, exp_of(hist[LAT]));
  end

  task automatic chk(input string nm, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic model(input int n, input int m, output int err, output int idx,
                       output int e0, output int g0);
    logic [2:0] e, g;
    err = 0; idx = 0; e0 = 0; g0 = 0;
    for (int k = 0; k < n; k++) begin
      e = exp_of(vec_k(k));
      g = cut(m, e);
      if (g != e) begin
        if (err == 0) begin idx = k; e0 = int'(e); g0 = int'(g); end
        err++;
      end
    end
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_vec = 16'(n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the negedge of cycle cyc0 (cycle 1 = first cycle after start sampled)
  task automatic wait_done(input int n, input int cyc0, output int cyc_done,
                           output bit saw_busy, output bit seq_ok);
    int cyc;
    cyc = cyc0; saw_busy = 0; seq_ok = 1; cyc_done = -1;
    while (cyc < 2000) begin
      if (bus.busy) saw_busy = 1;
      if (cyc <= n) begin
        if ({bus.C1, bus.C0} != vec_k(cyc - 1)) seq_ok = 0;
      end else if ({bus.C1, bus.C0} != 6'd0) seq_ok = 0;
      if (bus.done) begin cyc_done = cyc; break; end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_check(input string nm, input int n, input int m, input int err,
                           input int idx, input int e0, input int g0);
    int cd; bit sb, sq;
    mode = m;
    do_start(n);
    wait_done(n, 1, cd, sb, sq);
    chk({nm, ".done_cycle"}, cd, (n == 0) ? 1 : n + LAT + 1);
    chk({nm, ".busy_seen"}, sb, (n != 0));
    chk({nm, ".stim_seq"}, sq, 1);
    chk({nm, ".err_cnt"}, bus.err_cnt, err);
    chk({nm, ".pass"}, bus.pass, (err == 0));
    chk({nm, ".first_idx"}, bus.first_err_idx, idx);
    chk({nm, ".first_exp"}, bus.first_err_exp, e0);
    chk({nm, ".first_got"}, bus.first_err_got, g0);
  endtask

  function automatic longint all_out();
    return longint'({bus.C0, bus.C1, bus.busy, bus.done, bus.pass, bus.err_cnt,
                     bus.first_err_idx, bus.first_err_exp, bus.first_err_got});
  endfunction

  typedef struct {
    int n; int m; int err; int idx; int e0; int g0;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int cd, err, idx, e0, g0, n, m;
    bit sb, sq, seen;

    tbl[0] = '{n: 1,  m: 0, err: 0, idx: 0, e0: 0, g0: 0};
    tbl[1] = '{n: 0,  m: 0, err: 0, idx: 0, e0: 0, g0: 0};
    tbl[2] = '{n: 4,  m: 1, err: 4, idx: 0, e0: 3, g0: 0};
    tbl[3] = '{n: 4,  m: 2, err: 1, idx: 3, e0: 4, g0: 5};
    tbl[4] = '{n: 4,  m: 3, err: 4, idx: 0, e0: 3, g0: 2};
    tbl[5] = '{n: 64, m: 0, err: 0, idx: 0, e0: 0, g0: 0};
`ifdef COUNTER_15_HWCHECK_EXHAUSTIVE_EN
    foreach (tbl[i]) model(tbl[i].n, tbl[i].m, tbl[i].err, tbl[i].idx, tbl[i].e0, tbl[i].g0);
`endif

    rst = 1'b1; bus.start = 1'b0; bus.num_vec = '0;
    repeat (3) @(negedge clk);
    chk("reset.outputs", all_out(), 0);
    rst = 1'b0;

    foreach (tbl[i])
      run_check($sformatf("tbl%0d", i), tbl[i].n, tbl[i].m, tbl[i].err,
                tbl[i].idx, tbl[i].e0, tbl[i].g0);

    // second start in RUN is ignored
    mode = 0;
    do_start(10);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.num_vec = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(10, 4, cd, sb, sq);
    chk("midstart.done_cycle", cd, 10 + LAT + 1);
    chk("midstart.stim_seq", sq, 1);
    chk("midstart.pass", bus.pass, 1);

    // start in DONE after a failed run clears the error record
    run_check("failrun", 4, 1, 4, 0, 3, 0);
    do_start(5);
    chk("restart.err_cnt", bus.err_cnt, 0);
    chk("restart.first", {bus.first_err_idx, bus.first_err_exp, bus.first_err_got}, 0);
    chk("restart.busy", bus.busy, 1);
    wait_done(5, 1, cd, sb, sq);
    chk("restart.done_cycle", cd, 5 + LAT + 1);
    chk("restart.err_after", bus.err_cnt, 5);

    // rst in the third RUN cycle aborts with no done
    mode = 1;
    do_start(10);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.outputs", all_out(), 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("abort.quiet", seen, 0);

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 40);
      m = $urandom_range(0, 3);
      model(n, m, err, idx, e0, g0);
      run_check($sformatf("rnd%0d", r), n, m, err, idx, e0, g0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
